// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register address width, forwarding select encoding and
// the per-stage shadow records kept by the hazard controller.
package cpu_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // What every shadow stage needs to know about its occupant's write-back.
  typedef struct packed {
    logic      valid;
    logic      wr_en;
    reg_addr_t wr_addr;
    logic      is_load;
  } stage_t;

  // Source operands, only tracked for the instruction sitting in EX.
  typedef struct packed {
    reg_addr_t rs;
    reg_addr_t rt;
    logic      uses_rs;
    logic      uses_rt;
  } ex_src_t;

  localparam stage_t  STAGE_EMPTY  = '0;
  localparam ex_src_t EX_SRC_EMPTY = '0;

  // Operand select for one EX source: the youngest non-load producer wins, $0 never forwards.
  function automatic logic [1:0] fwd_sel(input logic      ex_valid,
                                         input logic      uses,
                                         input reg_addr_t src,
                                         input stage_t    mem,
                                         input stage_t    wb);
    logic [1:0] sel;
    sel = FWD_RF;
    if (ex_valid && uses && (src != '0)) begin
      if (mem.valid && mem.wr_en && (mem.wr_addr == src) && !mem.is_load) begin
        sel = FWD_MEM;
      end else if (wb.valid && wb.wr_en && (wb.wr_addr == src)) begin
        sel = FWD_WB;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave):
// decoded ID fields and stage events in, stall/flush/forward controls out.
interface hazard_ctrl_if;
  import cpu_pkg::*;

  logic      id_valid;
  reg_addr_t id_rs;
  reg_addr_t id_rt;
  logic      id_uses_rs;
  logic      id_uses_rt;
  logic      id_wr_en;
  reg_addr_t id_wr_addr;
  logic      id_is_load;
  logic      id_is_muldiv;
  logic      id_reads_hilo;
  logic      ex_branch_taken;
  logic      mem_stall;

  logic       stall_if;
  logic       stall_id;
  logic       bubble_ex;
  logic       flush_id;
  logic       freeze;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       muldiv_busy;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en, id_wr_addr,
           id_is_load, id_is_muldiv, id_reads_hilo, ex_branch_taken, mem_stall,
    input  stall_if, stall_id, bubble_ex, flush_id, freeze, fwd_a_sel, fwd_b_sel,
           muldiv_busy
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_wr_en, id_wr_addr,
           id_is_load, id_is_muldiv, id_reads_hilo, ex_branch_taken, mem_stall,
    output stall_if, stall_id, bubble_ex, flush_id, freeze, fwd_a_sel, fwd_b_sel,
           muldiv_busy
  );

endinterface

// File: rtl/muldiv_seq.sv
// Mul/div occupancy counter: loaded on issue into EX, counts down on every unfrozen cycle.
module muldiv_seq #(
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue_i,
  input  logic advance_i,
  output logic busy_o
);

  localparam int unsigned CntW = 6;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (advance_i) begin
      if (issue_i) begin
        cnt_d = CntW'(MULDIV_CYCLES);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: shadows EX/MEM/WB, raises load-use and HI/LO stalls,
// branch flushes and memory freezes, and picks the EX operand forwarding sources.
module hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES = 32
) (
  input logic          clk,
  input logic          rst_n,
  hazard_ctrl_if.slave bus
);

  stage_t  ex_q, ex_d;
  stage_t  mem_q, mem_d;
  stage_t  wb_q, wb_d;
  ex_src_t ex_src_q, ex_src_d;

  logic lu_hazard;
  logic hl_hazard;
  logic advance;
  logic muldiv_busy;
  logic muldiv_issue;

  logic stall_if;
  logic stall_id;
  logic bubble_ex;
  logic flush_id;
  logic freeze;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    lu_hazard = 1'b0;
    if (bus.id_valid && ex_q.valid && ex_q.is_load && ex_q.wr_en && (ex_q.wr_addr != '0)) begin
      lu_hazard = (bus.id_uses_rs && (bus.id_rs == ex_q.wr_addr)) ||
                  (bus.id_uses_rt && (bus.id_rt == ex_q.wr_addr));
    end
  end

  assign hl_hazard = bus.id_valid && (bus.id_reads_hilo || bus.id_is_muldiv) && muldiv_busy;

  // Priority: memory freeze, then branch flush, then ID-side stalls.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    bubble_ex = 1'b0;
    flush_id  = 1'b0;
    freeze    = 1'b0;
    if (bus.mem_stall) begin
      freeze   = 1'b1;
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else if (bus.ex_branch_taken) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (lu_hazard || hl_hazard) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      bubble_ex = 1'b1;
    end
  end

  assign advance      = !bus.mem_stall;
  assign muldiv_issue = bus.id_valid && bus.id_is_muldiv && !bubble_ex;

  always_comb begin
    ex_d     = ex_q;
    ex_src_d = ex_src_q;
    mem_d    = mem_q;
    wb_d     = wb_q;
    if (advance) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      if (bubble_ex) begin
        ex_d     = STAGE_EMPTY;
        ex_src_d = EX_SRC_EMPTY;
      end else begin
        ex_d.valid       = bus.id_valid;
        ex_d.wr_en       = bus.id_wr_en;
        ex_d.wr_addr     = bus.id_wr_addr;
        ex_d.is_load     = bus.id_is_load;
        ex_src_d.rs      = bus.id_rs;
        ex_src_d.rt      = bus.id_rt;
        ex_src_d.uses_rs = bus.id_uses_rs;
        ex_src_d.uses_rt = bus.id_uses_rt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= STAGE_EMPTY;
      ex_src_q <= EX_SRC_EMPTY;
      mem_q    <= STAGE_EMPTY;
      wb_q     <= STAGE_EMPTY;
    end else begin
      ex_q     <= ex_d;
      ex_src_q <= ex_src_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
    end
  end

  muldiv_seq #(
    .MULDIV_CYCLES(MULDIV_CYCLES)
  ) u_muldiv_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .issue_i  (muldiv_issue),
    .advance_i(advance),
    .busy_o   (muldiv_busy)
  );

  assign bus.stall_if    = stall_if;
  assign bus.stall_id    = stall_id;
  assign bus.bubble_ex   = bubble_ex;
  assign bus.flush_id    = flush_id;
  assign bus.freeze      = freeze;
  assign bus.muldiv_busy = muldiv_busy;
  assign bus.fwd_a_sel   = fwd_sel(ex_q.valid, ex_src_q.uses_rs, ex_src_q.rs, mem_q, wb_q);
  assign bus.fwd_b_sel   = fwd_sel(ex_q.valid, ex_src_q.uses_rt, ex_src_q.rt, mem_q, wb_q);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: instruction-level pipeline model predicts each cycle's
// controls; a separate monitor compares the DUT against the queued predictions.
module tb_hazard_ctrl;

  localparam int unsigned Cyc = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hazard_ctrl_if hif ();

  hazard_ctrl #(
    .MULDIV_CYCLES(Cyc)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (hif.slave)
  );

  typedef struct {
    bit v;
    int rs;
    int rt;
    bit urs;
    bit urt;
    bit we;
    int wa;
    bit ld;
    bit md;
    bit hilo;
  } ins_t;

  typedef struct packed {
    logic       stall_if;
    logic       stall_id;
    logic       bubble;
    logic       flush;
    logic       freeze;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       busy;
  } out_t;

  // pipe[0]=EX, pipe[1]=MEM, pipe[2]=WB; md_left = cycles the mul/div unit is still busy
  ins_t  pipe[3];
  int    md_left;
  out_t  exp_q[$];
  string tag_q[$];
  int    tests = 0;
  int    fails = 0;

  function automatic ins_t mk(bit v, int rs, int rt, bit urs, bit urt, bit we, int wa,
                              bit ld, bit md, bit hilo);
    ins_t i;
    i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
    i.we = we; i.wa = wa; i.ld = ld; i.md = md; i.hilo = hilo;
    return i;
  endfunction

  function automatic ins_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic bit writes(ins_t i, int r);
    return i.v && i.we && (i.wa == r);
  endfunction

  // Which older instruction supplies register src to the instruction in EX.
  function automatic int fwd(int src, bit use_it);
    if (!pipe[0].v || !use_it || src == 0) return 0;
    if (writes(pipe[1], src) && !pipe[1].ld) return 1;
    if (writes(pipe[2], src)) return 2;
    return 0;
  endfunction

  task automatic step(input ins_t id, input bit br, input bit ms, input bit rst,
                      input string tag);
    out_t e;
    bit   lu;
    bit   hl;
    @(negedge clk);
    rst_n               = !rst;
    hif.id_valid        = id.v;
    hif.id_rs           = id.rs[4:0];
    hif.id_rt           = id.rt[4:0];
    hif.id_uses_rs      = id.urs;
    hif.id_uses_rt      = id.urt;
    hif.id_wr_en        = id.we;
    hif.id_wr_addr      = id.wa[4:0];
    hif.id_is_load      = id.ld;
    hif.id_is_muldiv    = id.md;
    hif.id_reads_hilo   = id.hilo;
    hif.ex_branch_taken = br;
    hif.mem_stall       = ms;
    if (rst) begin
      for (int k = 0; k < 3; k++) pipe[k] = nop();
      md_left = 0;
    end
    lu = id.v && pipe[0].v && pipe[0].ld && pipe[0].we && pipe[0].wa != 0 &&
         ((id.urs && id.rs == pipe[0].wa) || (id.urt && id.rt == pipe[0].wa));
    hl = id.v && (id.hilo || id.md) && md_left > 0;
    e = '0;
    if (ms) begin
      e.freeze = 1; e.stall_if = 1; e.stall_id = 1;
    end else if (br) begin
      e.flush = 1; e.bubble = 1;
    end else if (lu || hl) begin
      e.stall_if = 1; e.stall_id = 1; e.bubble = 1;
    end
    e.fa   = 2'(fwd(pipe[0].rs, pipe[0].urs));
    e.fb   = 2'(fwd(pipe[0].rt, pipe[0].urt));
    e.busy = (md_left > 0);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    if (!rst && !ms) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = e.bubble ? nop() : id;
      if (id.v && id.md && !e.bubble) md_left = Cyc;
      else if (md_left > 0) md_left--;
    end
  endtask

  initial begin : monitor
    out_t  e;
    out_t  a;
    string t;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        a = {hif.stall_if, hif.stall_id, hif.bubble_ex, hif.flush_id, hif.freeze,
             hif.fwd_a_sel, hif.fwd_b_sel, hif.muldiv_busy};
        tests++;
        if (a !== e) begin
          fails++;
          $display("FAIL %s: got sif/sid/bub/fl/frz/fa/fb/busy=%b required %b", t, a, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    ins_t lw, use_i, mult, mfhi;
    for (int k = 0; k < 3; k++) pipe[k] = nop();
    md_left = 0;
    step(nop(), 0, 0, 1, "reset0");
    step(nop(), 0, 0, 1, "reset1");
    step(nop(), 0, 0, 0, "idle");

    // load-use: LW $8 then ADD $9,$8,$1
    lw    = mk(1, 0, 0, 0, 0, 1, 8, 1, 0, 0);
    use_i = mk(1, 8, 1, 1, 1, 1, 9, 0, 0, 0);
    step(lw, 0, 0, 0, "lu_lw");
    step(use_i, 0, 0, 0, "lu_stall");
    step(use_i, 0, 0, 0, "lu_release");
    step(nop(), 0, 0, 0, "lu_fwd_wb");

    // EX/MEM forward, then $0 destination
    step(mk(1, 1, 2, 1, 1, 1, 3, 0, 0, 0), 0, 0, 0, "add3");
    step(mk(1, 3, 3, 1, 1, 1, 4, 0, 0, 0), 0, 0, 0, "sub_r3");
    step(nop(), 0, 0, 0, "fwd_mem");
    step(mk(1, 1, 2, 1, 1, 1, 0, 0, 0, 0), 0, 0, 0, "add0");
    step(mk(1, 0, 0, 1, 1, 1, 4, 0, 0, 0), 0, 0, 0, "sub_r0");
    step(nop(), 0, 0, 0, "fwd_r0");

    // $5 produced in both MEM and WB
    step(mk(1, 1, 1, 1, 0, 1, 5, 0, 0, 0), 0, 0, 0, "w5a");
    step(mk(1, 1, 1, 1, 0, 1, 5, 0, 0, 0), 0, 0, 0, "w5b");
    step(mk(1, 5, 5, 1, 1, 1, 6, 0, 0, 0), 0, 0, 0, "rd5");
    step(nop(), 0, 0, 0, "double_hit");

    // branch coinciding with load-use
    step(mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0), 0, 0, 0, "lw7");
    step(mk(1, 7, 0, 1, 0, 1, 2, 0, 0, 0), 1, 0, 0, "br_lu");
    step(mk(1, 7, 0, 1, 0, 1, 2, 0, 0, 0), 0, 0, 0, "br_after");

    // MULT then MFHI stalls for the full busy window
    mult = mk(1, 1, 2, 1, 1, 0, 0, 0, 1, 0);
    mfhi = mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 1);
    step(mult, 0, 0, 0, "mult");
    for (int k = 0; k < 4; k++) step(mfhi, 0, 0, 0, "hl_stall");
    step(mfhi, 0, 0, 0, "hl_release");

    // freeze during an active forward, then asynchronous reset while busy
    step(mk(1, 1, 1, 1, 0, 1, 6, 0, 0, 0), 0, 0, 0, "w6");
    step(mk(1, 6, 6, 1, 1, 1, 2, 0, 0, 0), 0, 0, 0, "rd6");
    for (int k = 0; k < 3; k++) step(nop(), 0, 1, 0, "ms_hold");
    step(nop(), 0, 0, 0, "ms_resume");
    step(mult, 0, 0, 0, "mult2");
    step(mfhi, 0, 0, 0, "hl_pre_rst");
    step(mfhi, 0, 0, 1, "rst_mid");
    step(nop(), 0, 0, 1, "rst_hold");
    step(nop(), 0, 0, 0, "rst_release");

    for (int n = 0; n < 1500; n++) begin
      ins_t r;
      r = mk(($urandom % 8) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 3),
             ($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 10) == 0);
      if (($urandom % 300) == 0) step(nop(), 0, 0, 1, "rand_rst");
      else step(r, ($urandom % 10) == 0, ($urandom % 7) == 0, 0, "rand");
    end

    @(negedge clk);
    @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending predictions required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline hazard controller for the 5-stage CPU: IF, ID, EX, MEM, WB.
- Takes the decoded register fields and class flags of the instruction in ID and keeps its own shadow of the EX, MEM and WB stages.
- Produces stall, flush and bubble controls, plus forwarding selects for the EX operand muxes.
- Also sequences the multi-cycle mul/div unit: it holds the busy counter and stalls HI/LO readers.

Parameters:
- MULDIV_CYCLES, 32, number of cycles the mul/div unit stays busy after issue (legal range 2..63).
- REG_ADDR_W, 5, register address width.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a real instruction.
- id_rs  input  5  ID source register rs.
- id_rt  input  5  ID source register rt.
- id_uses_rs  input  1  ID instruction reads rs.
- id_uses_rt  input  1  ID instruction reads rt.
- id_wr_en  input  1  ID instruction writes the GPR file.
- id_wr_addr  input  5  ID destination (rd or rt, already selected).
- id_is_load  input  1  ID instruction is a load.
- id_is_muldiv  input  1  ID instruction starts mul/div.
- id_reads_hilo  input  1  ID instruction is MFHI or MFLO.
- ex_branch_taken  input  1  branch/jump in EX redirects the PC this cycle.
- mem_stall  input  1  data memory not ready; freeze the whole pipe.
- stall_if  output  1  hold the PC.
- stall_id  output  1  hold the IF/ID register.
- bubble_ex  output  1  load a NOP into ID/EX.
- flush_id  output  1  clear IF/ID.
- freeze  output  1  hold ID/EX, EX/MEM and MEM/WB.
- fwd_a_sel  output  2  EX rs operand: 00 regfile, 01 EX/MEM, 10 MEM/WB.
- fwd_b_sel  output  2  EX rt operand: same encoding.
- muldiv_busy  output  1  mul/div in progress.

Behaviour:
- All outputs are combinational from internal state plus the ID inputs (0-cycle latency). Internal state updates on the rising edge of clk.
- Shadow stages (EX, MEM, WB) each hold: valid, wr_en, wr_addr, is_load. The EX stage additionally holds rs, rt, uses_rs, uses_rt.
- Reset (rst_n=0, asynchronous):
  - all shadow valid bits = 0; muldiv counter = 0.
  - Outputs are therefore stall_if=stall_id=bubble_ex=flush_id=0 and fwd_*=00.
  - freeze follows mem_stall.
  - muldiv_busy=0.
- Load-use hazard (lu):
  - Condition: id_valid & EX.valid & EX.is_load & EX.wr_en & EX.wr_addr != 0, and (id_uses_rs & id_rs == EX.wr_addr, or id_uses_rt & id_rt == EX.wr_addr).
  - Response: stall_if=stall_id=bubble_ex=1 for exactly one cycle.
- HI/LO hazard (hl):
  - Condition: id_valid & (id_reads_hilo | id_is_muldiv) & muldiv_busy.
  - Response: stall_if=stall_id=bubble_ex=1 until the counter reaches 0.
- Branch flush:
  - Condition: ex_branch_taken.
  - Response: flush_id=1 and bubble_ex=1. Flush has priority over lu and hl, so stall_if=stall_id=0 that cycle.
- Memory stall:
  - Condition: mem_stall=1.
  - Response: freeze=stall_if=stall_id=1, bubble_ex=0, flush_id=0. The shadow stages hold and the muldiv counter holds.
  - Priority: mem_stall overrides everything. A branch flush that coincides with mem_stall is not lost; EX keeps the branch and ex_branch_taken stays asserted until the pipe resumes.
- Shadow advance when not frozen:
  - WB<=MEM and MEM<=EX.
  - EX<=ID fields gated by id_valid, or an invalid entry if bubble_ex=1.
- Forwarding (per EX operand, rs shown; rt identical):
  - Forwarding applies only when EX.valid & EX.uses_rs & EX.rs != 0.
  - If MEM.valid & MEM.wr_en & MEM.wr_addr == EX.rs & !MEM.is_load, select 01.
  - Else if WB.valid & WB.wr_en & WB.wr_addr == EX.rs, select 10.
  - Else select 00.
  - MEM-stage load results are never forwarded; the lu stall guarantees they are not needed.
- Muldiv counter:
  - Loaded with MULDIV_CYCLES when an instruction with id_is_muldiv advances into EX (id_valid, not bubbled, not frozen).
  - Decrements by 1 per unfrozen cycle while nonzero.
  - muldiv_busy = (counter != 0). A muldiv issued while busy is stalled by hl.
- Register 0 never causes a hazard or a forward.

Decomposition:
- Shared package (cpu_pkg) holds:
  - fwd select constants FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10;
  - REG_ADDR_W;
  - the stage-shadow struct typedef {valid, wr_en, wr_addr, is_load}.
- One natural sub-module: muldiv_seq, containing the counter, load/decrement logic and muldiv_busy.

Test Plan:
1. Load-use: LW $8 in EX (is_load, wr_addr=8), ID ADD $9,$8,$1 with uses_rs → stall_if=stall_id=bubble_ex=1 for 1 cycle. Next cycle there is no stall, and fwd_a_sel=10 once the ADD reaches EX.
2. EX/MEM forward: ADD $3,... followed directly by SUB $4,$3,$3 → with SUB in EX, fwd_a_sel=fwd_b_sel=01. With $0 as the destination instead, both stay 00.
3. Double hit: $5 written in both MEM and WB and read in EX → fwd_a_sel=01 (the MEM stage wins).
4. Branch plus load-use the same cycle: ex_branch_taken=1 with an lu condition present → flush_id=1, bubble_ex=1, stall_if=0. The next cycle shows no residual stall.
5. Muldiv: MULT issues with MULDIV_CYCLES=4, then MFHI in ID → hl stall for 4 cycles; muldiv_busy falls on cycle 4 and MFHI advances.
6. mem_stall held for 3 cycles during an active forward → freeze=1, and fwd selects hold their values and stay stable. Asserting rst_n=0 mid-sequence immediately clears muldiv_busy and all stalls.
